// File: rtl/sobolflex_multi_pkg.sv
// rtl/sobolflex_multi_pkg.sv - shared sizing and default direction-vector helpers for sobolflex_multi
package sobolflex_multi_pkg;

    // Select/index ports keep at least one bit so a single dimension still has a legal port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Van der Corput vectors: v[k] = 1 << (bitwidth-1-k).
    function automatic logic [31:0] vdc_vector(input int bitwidth, input int k);
        return 32'h1 << (bitwidth - 1 - k);
    endfunction

endpackage

// File: rtl/sobolflex_multi_lsz.sv
// rtl/sobolflex_multi_lsz.sv - least-significant-zero encoder, one-hot select plus all-ones flag
module sobolflex_multi_lsz #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] onehot,
    output logic         none
);

    // Adding one ripples through the trailing ones and lands on the lowest zero.
    assign onehot = ~value & (value + 1'b1);
    assign none   = &value;

endmodule

// File: rtl/sobolflex_multi.sv
// rtl/sobolflex_multi.sv - multi-dimensional Sobol point generator with runtime direction vectors
module sobolflex_multi
    import sobolflex_multi_pkg::*;
#(
    parameter  int BITWIDTH = 8,
    parameter  int NUMDIM   = 2,
    localparam int DIM_W    = sel_width(NUMDIM),
    localparam int IDX_W    = sel_width(BITWIDTH)
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iEn,
    input  logic                       iClr,
    input  logic                       iReady,
    input  logic                       iDirWe,
    input  logic [DIM_W-1:0]           iDirDim,
    input  logic [IDX_W-1:0]           iDirIdx,
    input  logic [BITWIDTH-1:0]        iDirData,
    output logic                       oValid,
    output logic [NUMDIM*BITWIDTH-1:0] oRand,
    output logic [BITWIDTH-1:0]        oIdx,
    output logic                       oWrap
);

    logic [BITWIDTH-1:0]        vec [NUMDIM][BITWIDTH];
    logic [BITWIDTH-1:0]        sel;
    logic                       idx_full;
    logic [NUMDIM*BITWIDTH-1:0] step;
    logic                       advance;
    logic                       dim_ok;
    logic                       idx_ok;
    logic [DIM_W-1:0]           dim_sel;

    sobolflex_multi_lsz #(.W(BITWIDTH)) u_lsz (
        .value  (oIdx),
        .onehot (sel),
        .none   (idx_full)
    );

    assign advance = oValid & iReady;
    assign dim_ok  = (NUMDIM == 1) || (int'(iDirDim) < NUMDIM);
    assign idx_ok  = int'(iDirIdx) < BITWIDTH;
    assign dim_sel = (NUMDIM == 1) ? '0 : iDirDim;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int d = 0; d < NUMDIM; d++)
                for (int k = 0; k < BITWIDTH; k++)
                    vec[d][k] <= BITWIDTH'(vdc_vector(BITWIDTH, k));
        end else if (iDirWe && dim_ok && idx_ok) begin
            vec[dim_sel][iDirIdx] <= iDirData;
        end
    end

    // One-hot AND-OR select of v[d][c]; reads the registered bank, so a same-edge write is not seen.
    always_comb begin
        step = '0;
        for (int d = 0; d < NUMDIM; d++)
            for (int k = 0; k < BITWIDTH; k++)
                step[d*BITWIDTH +: BITWIDTH] = step[d*BITWIDTH +: BITWIDTH]
                                             | (vec[d][k] & {BITWIDTH{sel[k]}});
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid <= 1'b0;
            oRand  <= '0;
            oIdx   <= '0;
            oWrap  <= 1'b0;
        end else begin
            oValid <= iEn & ~iClr;
            oWrap  <= 1'b0;
            if (iClr) begin
                oRand <= '0;
                oIdx  <= '0;
            end else if (advance) begin
                if (idx_full) begin
                    oRand <= '0;
                    oIdx  <= '0;
                    oWrap <= 1'b1;
                end else begin
                    oRand <= oRand ^ step;
                    oIdx  <= oIdx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobolflex_multi.sv
// tb/tb_sobolflex_multi.sv - self-checking scoreboard bench for sobolflex_multi
module tb_sobolflex_multi;

    localparam int BW = 8;
    localparam int ND = 2;

    logic           iClk = 1'b0;
    logic           iRst, iEn, iClr, iReady, iDirWe;
    logic [0:0]     iDirDim;
    logic [2:0]     iDirIdx;
    logic [BW-1:0]  iDirData;
    logic           oValid;
    logic [ND*BW-1:0] oRand;
    logic [BW-1:0]  oIdx;
    logic           oWrap;

    sobolflex_multi #(.BITWIDTH(BW), .NUMDIM(ND)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iClr     (iClr),
        .iReady   (iReady),
        .iDirWe   (iDirWe),
        .iDirDim  (iDirDim),
        .iDirIdx  (iDirIdx),
        .iDirData (iDirData),
        .oValid   (oValid),
        .oRand    (oRand),
        .oIdx     (oIdx),
        .oWrap    (oWrap)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [BW-1:0]    idx;
        logic [ND*BW-1:0] pt;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [BW-1:0] m_v [ND][BW];
    logic [BW-1:0] m_idx;

    logic [BW-1:0] t1_seq [8] = '{8'd0, 8'd128, 8'd192, 8'd64, 8'd96, 8'd224, 8'd160, 8'd32};
    logic [BW-1:0] t2_vec [8] = '{8'd128, 8'd192, 8'd160, 8'd240, 8'd136, 8'd204, 8'd170, 8'd255};
    logic [BW-1:0] t2_seq [5] = '{8'd0, 8'd128, 8'd64, 8'd192, 8'd96};

    task automatic model_reset();
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < BW; k++)
                m_v[d][k] = 8'h80 >> k;
        m_idx = '0;
    endtask

    // Closed form: point n is the XOR of v[k] over the set bits of gray(n).
    function automatic logic [ND*BW-1:0] exp_point(input logic [BW-1:0] n);
        logic [BW-1:0]    g;
        logic [ND*BW-1:0] r;
        g = n ^ (n >> 1);
        r = '0;
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < BW; k++)
                if (g[k]) r[d*BW +: BW] = r[d*BW +: BW] ^ m_v[d][k];
        return r;
    endfunction

    task automatic push_model(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx = BW'(int'(m_idx) + i);
            e.pt  = exp_point(e.idx);
            sb.push_back(e);
        end
    endtask

    // Streams with iReady high, comparing each presented point against the queue front.
    task automatic drain();
        int   budget;
        logic wrap_exp;
        exp_t e;
        budget   = sb.size() + 20;
        wrap_exp = 1'b0;
        iEn      = 1'b1;
        iReady   = 1'b1;
        while (sb.size() > 0 && budget > 0) begin
            if (oValid === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (oIdx !== e.idx) begin
                    n_bad++;
                    $display("FAIL stream_idx: got %0d expected %0d", oIdx, e.idx);
                end
                n_cmp++;
                if (oRand !== e.pt) begin
                    n_bad++;
                    $display("FAIL stream_rand idx %0d: got %h expected %h", e.idx, oRand, e.pt);
                end
                n_cmp++;
                if (oWrap !== wrap_exp) begin
                    n_bad++;
                    $display("FAIL stream_wrap idx %0d: got %b expected %b", e.idx, oWrap, wrap_exp);
                end
                wrap_exp = (e.idx == 8'hFF);
                m_idx    = e.idx + 1'b1;
                if (sb.size() == 0) break;
            end
            budget--;
            @(negedge iClk);
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: %0d points outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge iClk);
        iReady = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iReady = 1'b0;
        iDirWe = 1'b0; iDirDim = '0; iDirIdx = '0; iDirData = '0;
        @(negedge iClk);
        @(negedge iClk);
        n_cmp++;
        if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", oValid); end
        n_cmp++;
        if (oRand !== '0) begin n_bad++; $display("FAIL reset_rand: got %h expected 0", oRand); end
        n_cmp++;
        if (oIdx !== '0) begin n_bad++; $display("FAIL reset_idx: got %0d expected 0", oIdx); end
        n_cmp++;
        if (oWrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b expected 0", oWrap); end
        iRst = 1'b0;
        iEn  = 1'b0;
        model_reset();
        @(negedge iClk);
    endtask

    task automatic test_vdc();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx = BW'(i);
            e.pt  = {t1_seq[i], t1_seq[i]};
            sb.push_back(e);
        end
        drain();
    endtask

    task automatic test_dir_write();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            iDirWe = 1'b1; iDirDim = 1'b1; iDirIdx = 3'(k); iDirData = t2_vec[k];
            @(negedge iClk);
            m_v[1][k] = t2_vec[k];
        end
        iDirWe = 1'b0;
        iClr   = 1'b1;
        @(negedge iClk);
        iClr  = 1'b0;
        m_idx = '0;
        for (int i = 0; i < 5; i++) begin
            e.idx = BW'(i);
            e.pt  = {t2_seq[i], t1_seq[i]};
            sb.push_back(e);
        end
        drain();
    endtask

    task automatic test_hold();
        logic [ND*BW-1:0] r;
        r = exp_point(m_idx);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            n_cmp++;
            if (oValid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b expected 1", oValid); end
            n_cmp++;
            if (oIdx !== 8'd5) begin n_bad++; $display("FAIL hold_idx: got %0d expected 5", oIdx); end
            n_cmp++;
            if (oRand !== r) begin n_bad++; $display("FAIL hold_rand: got %h expected %h", oRand, r); end
        end
        push_model(2);
        drain();
    endtask

    task automatic test_enable();
        iEn = 1'b0;
        @(negedge iClk);
        n_cmp++;
        if (oValid !== 1'b0) begin n_bad++; $display("FAIL en_drop_valid: got %b expected 0", oValid); end
        n_cmp++;
        if (oIdx !== m_idx) begin n_bad++; $display("FAIL en_drop_idx: got %0d expected %0d", oIdx, m_idx); end
        iEn = 1'b1;
        @(negedge iClk);
        n_cmp++;
        if (oValid !== 1'b1) begin n_bad++; $display("FAIL en_rise_valid: got %b expected 1", oValid); end
        n_cmp++;
        if (oIdx !== m_idx) begin n_bad++; $display("FAIL en_rise_idx: got %0d expected %0d", oIdx, m_idx); end
    endtask

    task automatic test_write_collision();
        logic [BW-1:0]    p, old0, old1;
        logic [ND*BW-1:0] r;
        int               c;
        p = m_idx;
        c = 0;
        for (int k = BW - 1; k >= 0; k--)
            if (!p[k]) c = k;
        r    = exp_point(p);
        old0 = m_v[0][c];
        old1 = m_v[1][c];
        iReady = 1'b1; iDirWe = 1'b1; iDirDim = 1'b0; iDirIdx = 3'(c); iDirData = 8'h5A;
        @(negedge iClk);
        iReady = 1'b0; iDirWe = 1'b0;
        m_v[0][c] = 8'h5A;
        n_cmp++;
        if (oIdx !== p + 1'b1) begin n_bad++; $display("FAIL coll_idx: got %0d expected %0d", oIdx, p + 1'b1); end
        n_cmp++;
        if (oRand[BW-1:0] !== (r[BW-1:0] ^ old0)) begin
            n_bad++;
            $display("FAIL coll_dim0: got %h expected %h", oRand[BW-1:0], r[BW-1:0] ^ old0);
        end
        n_cmp++;
        if (oRand[2*BW-1:BW] !== (r[2*BW-1:BW] ^ old1)) begin
            n_bad++;
            $display("FAIL coll_dim1: got %h expected %h", oRand[2*BW-1:BW], r[2*BW-1:BW] ^ old1);
        end
    endtask

    task automatic test_clear();
        iClr = 1'b1;
        @(negedge iClk);
        iClr  = 1'b0;
        m_idx = '0;
        push_model(10);
        drain();
        iReady = 1'b1; iClr = 1'b1;
        @(negedge iClk);
        iReady = 1'b0; iClr = 1'b0;
        n_cmp++;
        if (oValid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b expected 0", oValid); end
        n_cmp++;
        if (oIdx !== '0) begin n_bad++; $display("FAIL clr_idx: got %0d expected 0", oIdx); end
        n_cmp++;
        if (oRand !== '0) begin n_bad++; $display("FAIL clr_rand: got %h expected 0", oRand); end
        @(negedge iClk);
        n_cmp++;
        if (oValid !== 1'b1) begin n_bad++; $display("FAIL clr_return_valid: got %b expected 1", oValid); end
        n_cmp++;
        if (oIdx !== '0) begin n_bad++; $display("FAIL clr_return_idx: got %0d expected 0", oIdx); end
        m_idx = '0;
    endtask

    task automatic test_wrap();
        push_model(260);
        drain();
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        iEn = 1'b1; iReady = 1'b1;
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        n_cmp++;
        if (oValid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", oValid); end
        n_cmp++;
        if (oRand !== '0) begin n_bad++; $display("FAIL rst_mid_rand: got %h expected 0", oRand); end
        n_cmp++;
        if (oIdx !== '0) begin n_bad++; $display("FAIL rst_mid_idx: got %0d expected 0", oIdx); end
        iRst = 1'b0; iReady = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            e.idx = BW'(i);
            e.pt  = {t1_seq[i], t1_seq[i]};
            sb.push_back(e);
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge iClk);
        test_reset();
        test_vdc();
        test_dir_write();
        test_hold();
        test_enable();
        test_write_collision();
        test_clear();
        test_wrap();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
